// File: rtl/regbank_warb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regbank_warb : round-robin arbiter for the single register-bank write    |
// |                port; one registered write per cycle, global stall.       |
// | Optional: REGBANK_WARB_BYPASS_EN adds a same-cycle write bypass port.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regbank_warb #(
   parameter int NREQ  = 3,
   parameter int SELW  = 6,
   parameter int DATAW = 64,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*SELW-1:0]  req_sel,
   input  logic [NREQ*DATAW-1:0] req_val,
   output logic [NREQ-1:0]       req_ready,
   output logic                  regbank_we,
   output logic [SELW-1:0]       regbank_sel,
   output logic [DATAW-1:0]      regbank_valout,
   output logic [IDW-1:0]        grant_id,
   output logic                  busy
`ifdef REGBANK_WARB_BYPASS_EN
   ,
   input  logic [SELW-1:0]       byp_sel,
   output logic                  byp_hit,
   output logic [DATAW-1:0]      byp_val
`endif
);

   localparam logic [IDW:0] c_nreq = (IDW+1)'(NREQ);

   logic [IDW-1:0]   ptr_q, ptr_d;
   logic             we_q, we_d;
   logic [SELW-1:0]  sel_q, sel_d;
   logic [DATAW-1:0] val_q, val_d;
   logic [IDW-1:0]   id_q, id_d;

   logic             gnt_found;
   logic [IDW-1:0]   gnt_id;
   logic [IDW:0]     scan;

   // Scan ptr, ptr+1, ... with wrap; one extra bit keeps ptr+k from overflowing.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      scan      = '0;
      if (!stall) begin
         for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr_q} + (IDW+1)'(k);
            if (scan >= c_nreq) begin
               scan = scan - c_nreq;
            end
            if (!gnt_found && req_valid[scan[IDW-1:0]]) begin
               gnt_found = 1'b1;
               gnt_id    = scan[IDW-1:0];
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (gnt_found) begin
         req_ready[gnt_id] = 1'b1;
      end
   end

   assign busy = (|req_valid) && !gnt_found;

   always_comb begin
      ptr_d = ptr_q;
      we_d  = gnt_found;
      sel_d = sel_q;
      val_d = val_q;
      id_d  = id_q;
      if (gnt_found) begin
         ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
         sel_d = req_sel[int'(gnt_id)*SELW +: SELW];
         val_d = req_val[int'(gnt_id)*DATAW +: DATAW];
         id_d  = gnt_id;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
         we_q  <= 1'b0;
         sel_q <= '0;
         val_q <= '0;
         id_q  <= '0;
      end else begin
         ptr_q <= ptr_d;
         we_q  <= we_d;
         sel_q <= sel_d;
         val_q <= val_d;
         id_q  <= id_d;
      end
   end

   assign regbank_we     = we_q;
   assign regbank_sel    = sel_q;
   assign regbank_valout = val_q;
   assign grant_id       = id_q;

`ifdef REGBANK_WARB_BYPASS_EN
   // Exposes the write being committed this cycle to a same-cycle reader.
   assign byp_hit = we_q && (sel_q == byp_sel);
   assign byp_val = byp_hit ? val_q : '0;
`endif

endmodule
`default_nettype wire

// File: doc/regbank_warb.md
Name: regbank_warb

Overview:
- Round-robin arbiter that shares the single register-bank write port between NREQ writeback sources: control-unit immediate loads, ALU writeback and memory load return.
- Sits between the sources and the register bank.
- Drives the same regbank_we / regbank_sel / regbank_valout port bundle that the control unit drives today.
- Registered output: one write per cycle, fair rotation across sources, global stall.

Parameters:
- NREQ, 3, number of requesters (2..8).
- SELW, 6, register select width.
- DATAW, 64, register data width.
- IDW, $clog2(NREQ), width of the source-id field.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  when high, no grants issued this cycle.
- req_valid  input  NREQ  per-source write request.
- req_sel  input  NREQ*SELW  packed register selects; source i at [i*SELW +: SELW].
- req_val  input  NREQ*DATAW  packed write data; source i at [i*DATAW +: DATAW].
- req_ready  output  NREQ  one-hot (or zero) grant, combinational.
- regbank_we  output  1  register bank write enable, registered.
- regbank_sel  output  SELW  register bank select, registered.
- regbank_valout  output  DATAW  register bank write data, registered.
- grant_id  output  IDW  index of the source that produced the current regbank write, registered.
- busy  output  1  combinational; high when any req_valid is set and not granted this cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: regbank_we=0, regbank_sel=0, regbank_valout=0, grant_id=0, round-robin pointer ptr=0.
- Reset mid-operation: an in-flight write is dropped, i.e. regbank_we drops to 0 immediately, asynchronously.
- Transfer: occurs when req_valid[i] && req_ready[i] at a rising edge.
- Source rules: a source holds req_valid, req_sel and req_val stable until it is granted. A source may drop req_valid before grant; nothing is written.
- Grant selection (combinational):
  - If stall=1, req_ready is all zero.
  - Otherwise grant the first i with req_valid[i]=1, scanning ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - At most one bit of req_ready is set.
  - req_ready is never asserted for a source whose req_valid=0.
- Pointer update: on a grant to source g, ptr <= (g+1) mod NREQ. With no grant, ptr holds.
- Output latency: exactly one cycle.
  - A transfer at edge N gives regbank_we=1, regbank_sel=req_sel[g], regbank_valout=req_val[g] and grant_id=g, valid from edge N until edge N+1.
- No-grant cycles (idle, or stall=1): regbank_we <= 0. regbank_sel, regbank_valout and grant_id hold their last values.
- Back-to-back: a source may be granted again after at most NREQ-1 other grants. Continuous writes occur at one per cycle with no bubbles.
- Same-register collisions: two sources targeting the same register are serialised in grant order; the later grant wins in the bank. The arbiter does no merging and no dropping.
- busy = |req_valid && !(granted this cycle). busy is 1 during stall while any request is pending.
- Other: no internal FIFO; backpressure is purely through req_ready. Unknown or X inputs during reset are ignored.

Optional Feature:
- Macro: REGBANK_WARB_BYPASS_EN.
- When defined, three extra ports are added:
  - byp_sel  input  SELW
  - byp_hit  output  1
  - byp_val  output  DATAW
- Bypass logic (combinational): byp_hit = regbank_we && (regbank_sel == byp_sel). byp_val = regbank_valout when byp_hit, else 0. This lets a reader see the write being committed this cycle.
- When undefined, these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle: assert rst for 2 cycles with random req inputs. Expect regbank_we=0, sel=0, valout=0, grant_id=0 while rst=1. After release with req_valid=0, regbank_we stays 0.
- Single source: req_valid=3'b010, sel1=6'd5, val1=64'hDEAD_BEEF. Expect req_ready=3'b010 in the same cycle. Next cycle: regbank_we=1, sel=5, valout=DEAD_BEEF, grant_id=1, then regbank_we=0.
- All three continuously valid for 6 cycles from ptr=0. Expect grants 0,1,2,0,1,2 and regbank_we=1 for 6 consecutive cycles, one cycle delayed.
- Stall: hold stall=1 for 3 cycles with req_valid=3'b101. Expect req_ready=0, regbank_we=0 and busy=1 throughout. On release, source 0 is granted, then source 2.
- Reset mid-operation: assert rst asynchronously while regbank_we=1. Expect regbank_we=0 before the next edge and ptr=0, so the next grant goes to the lowest valid index.
- With REGBANK_WARB_BYPASS_EN: write sel=7, val=64'h1234, with byp_sel=7. Expect byp_hit=1 and byp_val=1234 during the output cycle. With byp_sel=8, expect byp_hit=0 and byp_val=0.
